// File: rtl/pattern_checker_pkg.sv
// pattern_checker_pkg: checker state type and pattern constants
// shared by the pattern source and the checker so both ends agree.
package pattern_checker_pkg;
  typedef enum logic {HUNT, LOCKED} state_e;
  localparam int DEF_STEP = 1;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_LOSS_COUNT = 8;
  localparam int DEF_ERR_W = 16;
endpackage

// File: rtl/pattern_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/pattern_checker.sv
// pattern_checker: locks onto an incrementing byte stream, then counts
// mismatches against a free-running expected sequence and drops lock on sustained errors.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int STEP       = DEF_STEP,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT = DEF_LOSS_COUNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic             clear_counters,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count
);
  localparam logic [7:0] STEP_B = 8'(STEP);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_e      state_q, state_d;
  logic        seeded_q, seeded_d;
  logic [7:0]  expected_q, expected_d;
  logic [3:0]  good_run_q, good_run_d;
  logic [3:0]  bad_run_q, bad_run_d;
  logic        error_pulse_q, error_pulse_d;
  logic [31:0] word_count_q, word_count_d;
  logic        mismatch, err_inc;

  assign mismatch = data_in != expected_q;
  assign err_inc  = data_valid && state_q == LOCKED && mismatch;

  always_comb begin
    state_d       = state_q;
    seeded_d      = seeded_q;
    expected_d    = expected_q;
    good_run_d    = good_run_q;
    bad_run_d     = bad_run_q;
    error_pulse_d = 1'b0;
    word_count_d  = word_count_q;
    if (data_valid && state_q == HUNT) begin
      expected_d = data_in + STEP_B;
      good_run_d = (seeded_q && !mismatch) ? good_run_q + 4'd1 : 4'd1;
      seeded_d   = 1'b1;
      if (good_run_d == LOCK_N) begin
        state_d   = LOCKED;
        bad_run_d = '0;
      end
    end else if (data_valid) begin
      // once locked the sequence free-runs; data never reseeds it
      expected_d    = expected_q + STEP_B;
      word_count_d  = word_count_q + 32'd1;
      error_pulse_d = mismatch;
      bad_run_d     = mismatch ? bad_run_q + 4'd1 : 4'd0;
      if (bad_run_d == LOSS_N) begin
        state_d    = HUNT;
        seeded_d   = 1'b0;
        good_run_d = '0;
      end
    end
    if (clear_counters) word_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      seeded_q      <= 1'b0;
      expected_q    <= '0;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      error_pulse_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      seeded_q      <= seeded_d;
      expected_q    <= expected_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      error_pulse_q <= error_pulse_d;
      word_count_q  <= word_count_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear_counters),
    .count (err_count)
  );

  assign locked      = state_q == LOCKED;
  assign error_pulse = error_pulse_q;
  assign word_count  = word_count_q;
endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: vector table, saturation sequence and random stream against a reference model.
module tb_pattern_checker;
  localparam int LC = 4;
  localparam int LS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0, data_valid = 1'b0, clear_counters = 1'b0;
  logic [7:0]  data_in = '0;
  logic        locked, error_pulse, locked2, pulse2;
  logic [15:0] err_count;
  logic [3:0]  err2;
  logic [31:0] word_count, words2;

  always #10 clk = ~clk;

  pattern_checker dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .clear_counters(clear_counters), .locked(locked), .error_pulse(error_pulse),
    .err_count(err_count), .word_count(word_count)
  );

  pattern_checker #(.LOSS_COUNT(15), .ERR_W(4)) dut2 (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .clear_counters(clear_counters), .locked(locked2), .error_pulse(pulse2),
    .err_count(err2), .word_count(words2)
  );

  int n_assert = 0, n_fail = 0;

  bit          m_locked, m_pulse;
  int          m_exp, m_bad;
  longint      m_err;
  logic [31:0] m_words;
  int          hunt[$];

  // lock is declared when the newest LC hunt words form one unbroken +1 run
  function automatic bit run_ok();
    int n = hunt.size();
    if (n < LC) return 1'b0;
    for (int i = n - LC + 1; i < n; i++)
      if (hunt[i] != ((hunt[i-1] + 1) & 255)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c);
    if (r) begin
      m_locked = 0; m_pulse = 0; m_exp = 0; m_bad = 0; m_err = 0; m_words = 0;
      hunt.delete();
      return;
    end
    m_pulse = 0;
    if (v && !m_locked) begin
      hunt.push_back(int'(d));
      if (run_ok()) begin
        m_locked = 1; m_exp = (int'(d) + 1) & 255; m_bad = 0;
        hunt.delete();
      end
    end else if (v) begin
      m_words = m_words + 1;
      if (int'(d) != m_exp) begin
        m_pulse = 1;
        if (m_err < 65535) m_err++;
        m_bad++;
        if (m_bad == LS) begin
          m_locked = 0;
          hunt.delete();
        end
      end else m_bad = 0;
      m_exp = (m_exp + 1) & 255;
    end
    if (c) begin
      m_err = 0; m_words = 0;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
    reset = r; data_valid = v; data_in = d; clear_counters = c;
    @(posedge clk);
    model_step(r, v, d, c);
    #1;
    check("model_locked", longint'(locked), longint'(m_locked));
    check("model_pulse", longint'(error_pulse), longint'(m_pulse));
    check("model_err", longint'(err_count), m_err);
    check("model_words", longint'(word_count), longint'(m_words));
  endtask

  typedef struct {
    bit r; bit v; logic [7:0] d; bit c;
    bit l; bit p; int e; int w;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input int d, input bit c,
                     input bit l, input bit p, input int e, input int w);
    vec_t x;
    x.r = r; x.v = v; x.d = 8'(d); x.c = c; x.l = l; x.p = p; x.e = e; x.w = w;
    tbl.push_back(x);
  endtask

  initial begin
    logic [7:0] nxt, s;
    int garbage;
    add(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 'h10 + i, 0, 0, 0, 0, 0);
    add(0, 1, 'h13, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 'h14 + i, 0, 1, 0, 0, i + 1);
    add(0, 1, 'h99, 0, 1, 1, 1, 5);
    for (int i = 0; i < 7; i++) add(0, 1, 'h19 + i, 0, 1, 0, 1, 6 + i);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 'hFB + i, 0, 0, 0, 0, 0);
    add(0, 1, 'hFE, 0, 1, 0, 0, 0);
    add(0, 1, 'hFF, 0, 1, 0, 0, 1);
    add(0, 1, 'h00, 0, 1, 0, 0, 2);
    add(0, 1, 'h01, 0, 1, 0, 0, 3);
    for (int i = 0; i < 7; i++) add(0, 1, 'hAA, 0, 1, 1, i + 1, 4 + i);
    add(0, 1, 'hAA, 0, 0, 1, 8, 11);
    for (int i = 0; i < 3; i++) add(0, 1, 'h40 + i, 0, 0, 0, 8, 11);
    add(0, 1, 'h43, 0, 1, 0, 8, 11);
    add(0, 1, 'h44, 0, 1, 0, 8, 12);
    add(0, 0, 'h55, 0, 1, 0, 8, 12);
    add(0, 1, 'h45, 0, 1, 0, 8, 13);
    add(0, 0, 'h00, 0, 1, 0, 8, 13);
    add(0, 1, 'h46, 0, 1, 0, 8, 14);
    add(0, 1, 'h00, 1, 1, 1, 0, 0);
    add(0, 1, 'h48, 0, 1, 0, 0, 1);
    add(0, 0, 'h00, 1, 1, 0, 0, 0);
    add(0, 1, 'h49, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 'h70 + i, 0, 0, 0, 0, 0);
    add(0, 1, 'h73, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("row%0d_locked", i), longint'(locked), longint'(tbl[i].l));
      check($sformatf("row%0d_pulse", i), longint'(error_pulse), longint'(tbl[i].p));
      check($sformatf("row%0d_err", i), longint'(err_count), longint'(tbl[i].e));
      check($sformatf("row%0d_words", i), longint'(word_count), longint'(tbl[i].w));
    end

    // saturation on the narrow-counter instance: alternate bad/good words to stay locked
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h20 + i), 0);
    s = 8'h24;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 8'hAA, 0);
      step(0, 1, s + 8'd1, 0);
      s = s + 8'd2;
      if (i == 13) check("sat_err_0xE", longint'(err2), 64'hE);
    end
    check("sat_err_0xF", longint'(err2), 64'hF);
    check("sat_locked", longint'(locked2), 64'd1);

    // random stream with corruption bursts, gaps, clears and rare resets
    step(1, 0, 0, 0);
    nxt = 8'($urandom);
    garbage = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, v, c;
      logic [7:0] d;
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 59) == 0);
      if (garbage == 0 && $urandom_range(0, 149) == 0) garbage = $urandom_range(3, 12);
      d = nxt;
      if (v) begin
        if (garbage > 0) begin
          d = 8'($urandom);
          garbage--;
        end else if ($urandom_range(0, 29) == 0) d = 8'($urandom);
        nxt = nxt + 8'd1;
      end
      step(r, v, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
